// File: rtl/ifetch_align.sv
// Instruction-fetch realigner: word fetches in, one raw instruction per cycle out.
// Build option IFA_RVC_EN enables 16-bit (RVC) instructions; otherwise all are 32-bit and odd-halfword targets trap.
module ifetch_align #(
   parameter int          FETCH_W  = 32,
   parameter int          DEPTH    = 8,
   parameter int          MAX_OS   = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               resetb,
   output logic               f_req,
   output logic [31:0]        f_addr,
   input  logic               f_gnt,
   input  logic               f_rvalid,
   input  logic [FETCH_W-1:0] f_rdata,
   input  logic               flush,
   input  logic [31:0]        flush_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic [31:0]        out_pc,
   output logic               out_is_c,
   output logic               out_misalign
);

   localparam int          NH         = FETCH_W / 16;
   localparam int          OFFB       = $clog2(FETCH_W / 8);
   localparam int          SW         = OFFB - 1;
   localparam int          AW         = $clog2(DEPTH);
   localparam int          CW         = AW + 1;
   localparam logic [31:0] ADDR_INC   = 32'(FETCH_W / 8);
   localparam logic [31:0] ALIGN_MASK = ~(ADDR_INC - 32'd1);

   logic          r_req;
   logic [31:0]   r_addr;
   logic [1:0]    r_os;
   logic [1:0]    r_drop;
   logic [SW-1:0] r_skip;
   logic [15:0]   r_buf [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_pc;
   logic          r_mis;
   logic          r_err_v;

   logic          w_gnt;
   logic          w_rv;
   logic          w_push;
   logic          w_pop;
   logic          w_is_c;
   logic          w_fl_mis;
   logic          w_valid;
   logic [15:0]   w_hw0;
   logic [15:0]   w_hw1;
   logic [CW-1:0] w_push_n;
   logic [CW-1:0] w_pop_n;
   logic [CW-1:0] w_cnt_n;
   logic [CW-1:0] w_free_n;
   logic [1:0]    w_os_n;
   logic [15:0]   w_need;
   logic          w_req_n;

   // Responses with nothing outstanding (e.g. in flight across a reset) are ignored.
   assign w_gnt  = r_req & f_gnt;
   assign w_rv   = f_rvalid & (r_os != 2'd0);
   assign w_push = w_rv & (r_drop == 2'd0);
   assign w_hw0  = r_buf[r_rd];
   assign w_hw1  = r_buf[r_rd + AW'(1)];

`ifdef IFA_RVC_EN
   assign w_is_c   = (r_cnt != '0) && (w_hw0[1:0] != 2'b11);
   assign w_fl_mis = 1'b0;
`else
   assign w_is_c   = 1'b0;
   assign w_fl_mis = flush & flush_pc[1];
`endif

   assign w_valid = r_mis ? r_err_v : (w_is_c | (r_cnt >= CW'(2)));
   assign w_pop   = w_valid & out_ready;

   always_comb begin
      w_push_n = '0;
      w_pop_n  = '0;
      if (w_push)
         w_push_n = CW'(NH) - CW'(r_skip);
      if (w_pop && !r_mis)
         w_pop_n = w_is_c ? CW'(1) : CW'(2);
      w_cnt_n  = r_cnt + w_push_n - w_pop_n;
      w_free_n = CW'(DEPTH) - w_cnt_n;
      w_os_n   = r_os + {1'b0, w_gnt} - {1'b0, w_rv};
      // Space for every outstanding response plus the new one is reserved up front.
      w_need   = 16'(NH) * (16'(w_os_n) + 16'd1);
      w_req_n  = (r_req & ~f_gnt) |
                 (~r_mis & (w_os_n < 2'(MAX_OS)) & (16'(w_free_n) >= w_need));
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_req   <= 1'b0;
         r_addr  <= RESET_PC & ALIGN_MASK;
         r_os    <= '0;
         r_drop  <= '0;
         r_skip  <= RESET_PC[OFFB-1:1];
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_pc    <= RESET_PC;
         r_mis   <= 1'b0;
         r_err_v <= 1'b0;
      end else if (flush) begin
         r_req   <= 1'b0;
         r_addr  <= flush_pc & ALIGN_MASK;
         r_os    <= w_os_n;
         r_drop  <= w_os_n;
         r_skip  <= flush_pc[OFFB-1:1];
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_pc    <= flush_pc & ~32'd1;
         r_mis   <= w_fl_mis;
         r_err_v <= w_fl_mis;
      end else begin
         r_req <= w_req_n;
         r_os  <= w_os_n;
         r_cnt <= w_cnt_n;
         if (w_gnt)
            r_addr <= r_addr + ADDR_INC;
         if (w_rv && (r_drop != 2'd0))
            r_drop <= r_drop - 2'd1;
         if (w_push) begin
            r_skip <= '0;
            r_wr   <= r_wr + AW'(w_push_n);
         end
         if (w_pop) begin
            if (r_mis) begin
               r_err_v <= 1'b0;
            end else begin
               r_rd <= r_rd + AW'(w_pop_n);
               r_pc <= r_pc + (w_is_c ? 32'd2 : 32'd4);
            end
         end
      end
   end

   // Halfword storage: lanes below the entry offset of a redirected fetch are skipped.
   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         for (int i = 0; i < NH; i++) begin
            if (AW'(i) >= AW'(r_skip))
               r_buf[r_wr + AW'(i) - AW'(r_skip)] <= f_rdata[16*i +: 16];
         end
      end
   end

   assign f_req        = r_req;
   assign f_addr       = r_addr;
   assign out_valid    = w_valid;
   assign out_inst     = r_mis ? 32'd0 : (w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0});
   assign out_pc       = r_pc;
   assign out_is_c     = w_is_c;
   assign out_misalign = r_mis;

endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align with an in-order, one-cycle-latency memory model.
// Covers both builds of IFA_RVC_EN.
module tb_ifetch_align;

   logic        clk = 1'b0;
   logic        resetb;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        flush;
   logic [31:0] flush_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_is_c;
   logic        out_misalign;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem [1024];
   logic [31:0] q_addr [$];
   int          budget  = 1000000;

   always #5 clk = ~clk;

   ifetch_align #(.FETCH_W(32), .DEPTH(8), .MAX_OS(2), .RESET_PC(32'h0)) dut (
      .clk(clk), .resetb(resetb), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata), .flush(flush), .flush_pc(flush_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_is_c(out_is_c), .out_misalign(out_misalign));

   // Memory model: answers each granted request one cycle later, in order, while budget lasts.
   initial begin
      logic [31:0] a;
      f_rvalid = 1'b0;
      f_rdata  = '0;
      forever begin
         @(negedge clk);
         #1;
         f_rvalid = 1'b0;
         if (q_addr.size() > 0 && budget > 0) begin
            a        = q_addr.pop_front();
            f_rvalid = 1'b1;
            f_rdata  = mem[a[11:2]];
            budget--;
         end
         if (f_req && f_gnt)
            q_addr.push_back(f_addr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic get_inst(output bit ok, output logic [31:0] inst, output logic [31:0] pc,
                           output logic isc);
      ok = 1'b0; inst = '0; pc = '0; isc = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (out_valid) begin
            inst = out_inst; pc = out_pc; isc = out_is_c;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush = 1'b1; flush_pc = pc;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic quiesce();
      budget = 1000000;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++; if (f_req !== 1'b0) begin n_fail++; $display("FAIL reset_f_req: got %0b want 0", f_req); end
      n_tests++; if (f_addr !== 32'h0) begin n_fail++; $display("FAIL reset_f_addr: got %h want 0", f_addr); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_tests++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      n_tests++; if (out_is_c !== 1'b0) begin n_fail++; $display("FAIL reset_out_is_c: got %0b want 0", out_is_c); end
      n_tests++; if (out_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %0b want 0", out_misalign); end
   endtask

   task automatic test_first_fetch();
      bit seen_req, done, ok;
      logic prev_v, c;
      logic [31:0] i, p;
      seen_req = 0; done = 0; prev_v = 1'b0;
      resetb = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (f_req && !seen_req) begin
            seen_req = 1;
            n_tests++; if (f_addr !== 32'h0) begin n_fail++; $display("FAIL first_f_addr: got %h want 0", f_addr); end
         end
         if (f_rvalid) begin
            done = 1;
            n_tests++;
            if (out_valid !== 1'b1 || prev_v !== 1'b0) begin
               n_fail++; $display("FAIL first_latency: valid=%0b prev=%0b want 1/0", out_valid, prev_v);
            end
         end
         prev_v = out_valid;
      end
      n_tests++; if (!done) begin n_fail++; $display("FAIL first_timeout: got no response want one"); end
      get_inst(ok, i, p, c);
      n_tests++;
      if (!ok || i !== 32'h13 || p !== 32'h0 || c !== 1'b0) begin
         n_fail++; $display("FAIL first_inst: ok=%0b inst=%h pc=%h c=%0b want 00000013/0/0", ok, i, p, c);
      end
      get_inst(ok, i, p, c);
      n_tests++;
      if (!ok || i !== 32'h00100093 || p !== 32'h4 || c !== 1'b0) begin
         n_fail++; $display("FAIL second_inst: ok=%0b inst=%h pc=%h c=%0b want 00100093/4/0", ok, i, p, c);
      end
   endtask

   task automatic test_word_kinds();
      bit ok; logic c; logic [31:0] i, p;
      do_flush(32'h40);
`ifdef IFA_RVC_EN
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h4505 || p !== 32'h40 || c !== 1'b1) begin n_fail++; $display("FAIL rvc_lo: ok=%0b inst=%h pc=%h c=%0b want 00004505/40/1", ok, i, p, c); end
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h4501 || p !== 32'h42 || c !== 1'b1) begin n_fail++; $display("FAIL rvc_hi: ok=%0b inst=%h pc=%h c=%0b want 00004501/42/1", ok, i, p, c); end
`else
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h45014505 || p !== 32'h40 || c !== 1'b0) begin n_fail++; $display("FAIL word32: ok=%0b inst=%h pc=%h c=%0b want 45014505/40/0", ok, i, p, c); end
`endif
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h13 || p !== 32'h44 || c !== 1'b0) begin n_fail++; $display("FAIL word_next: ok=%0b inst=%h pc=%h c=%0b want 00000013/44/0", ok, i, p, c); end
   endtask

`ifdef IFA_RVC_EN
   task automatic test_straddle();
      bit ok; logic c; logic [31:0] i, p; int vcnt;
      quiesce();
      budget = 0;
      do_flush(32'h20);
      repeat (4) @(negedge clk);
      budget = 1;
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h4505 || p !== 32'h20 || c !== 1'b1) begin n_fail++; $display("FAIL strad_c0: ok=%0b inst=%h pc=%h c=%0b want 00004505/20/1", ok, i, p, c); end
      vcnt = 0;
      repeat (4) begin @(negedge clk); if (out_valid) vcnt++; end
      n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL strad_wait: valid cycles=%0d want 0", vcnt); end
      budget = 1000000;
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h13 || p !== 32'h22 || c !== 1'b0) begin n_fail++; $display("FAIL strad_32: ok=%0b inst=%h pc=%h c=%0b want 00000013/22/0", ok, i, p, c); end
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h4505 || p !== 32'h26 || c !== 1'b1) begin n_fail++; $display("FAIL strad_c1: ok=%0b inst=%h pc=%h c=%0b want 00004505/26/1", ok, i, p, c); end
   endtask
`endif

   task automatic test_flush_drop();
      bit ok, seen; logic c; logic [31:0] i, p, tgt, t_addr, t_inst; logic t_c;
`ifdef IFA_RVC_EN
      tgt = 32'h102; t_addr = 32'h100; t_inst = 32'h4505; t_c = 1'b1;
`else
      tgt = 32'h104; t_addr = 32'h104; t_inst = 32'h00500093; t_c = 1'b0;
`endif
      quiesce();
      budget = 0;
      do_flush(32'h80);
      repeat (4) @(negedge clk);
      n_tests++; if (f_req !== 1'b0) begin n_fail++; $display("FAIL os_limit_f_req: got %0b want 0", f_req); end
      budget = 1000000;
      do_flush(tgt);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (f_req) seen = 1; else @(negedge clk);
      end
      n_tests++; if (!seen || f_addr !== t_addr) begin n_fail++; $display("FAIL flush_f_addr: seen=%0b addr=%h want %h", seen, f_addr, t_addr); end
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== t_inst || p !== tgt || c !== t_c) begin n_fail++; $display("FAIL flush_inst: ok=%0b inst=%h pc=%h c=%0b want %h/%h/%0b", ok, i, p, c, t_inst, tgt, t_c); end
   endtask

   task automatic test_backpressure();
      bit ok; logic c; logic [31:0] i, p;
      out_ready = 1'b0;
      do_flush(32'h180);
      repeat (20) @(negedge clk);
      n_tests++; if (f_req !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall: f_req=%0b valid=%0b want 0/1", f_req, out_valid); end
      for (int k = 0; k < 8; k++) begin
         get_inst(ok, i, p, c);
         n_tests++;
         if (!ok || i !== (32'h13 | (32'(k) << 20)) || p !== 32'h180 + 32'(4*k) || c !== 1'b0) begin
            n_fail++; $display("FAIL bp_order[%0d]: ok=%0b inst=%h pc=%h want %h/%h", k, ok, i, p, 32'h13 | (32'(k) << 20), 32'h180 + 32'(4*k));
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok; logic c; logic [31:0] i, p;
      flush = 1'b1; flush_pc = 32'h300;
      @(negedge clk);
      flush_pc = 32'h200;
      @(negedge clk);
      flush = 1'b0;
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h00800093 || p !== 32'h200) begin n_fail++; $display("FAIL b2b_flush: ok=%0b inst=%h pc=%h want 00800093/200", ok, i, p); end
   endtask

   task automatic test_misalign();
      bit ok; logic c; logic [31:0] i, p; int rcnt;
      do_flush(32'h6);
`ifdef IFA_RVC_EN
      n_tests++; if (out_misalign !== 1'b0) begin n_fail++; $display("FAIL rvc_no_mis: got %0b want 0", out_misalign); end
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h0010 || p !== 32'h6 || c !== 1'b1) begin n_fail++; $display("FAIL rvc_pc6: ok=%0b inst=%h pc=%h c=%0b want 00000010/6/1", ok, i, p, c); end
`else
      n_tests++;
      if (out_misalign !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h6 || out_inst !== 32'h0) begin
         n_fail++; $display("FAIL mis_entry: mis=%0b valid=%0b pc=%h inst=%h want 1/1/6/0", out_misalign, out_valid, out_pc, out_inst);
      end
      rcnt = 0;
      repeat (10) begin @(negedge clk); if (f_req) rcnt++; end
      n_tests++; if (rcnt != 0) begin n_fail++; $display("FAIL mis_no_fetch: req cycles=%0d want 0", rcnt); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pop: valid=%0b mis=%0b want 0/1", out_valid, out_misalign); end
      do_flush(32'h8);
      n_tests++; if (out_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %0b want 0", out_misalign); end
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h00300093 || p !== 32'h8) begin n_fail++; $display("FAIL mis_resume: ok=%0b inst=%h pc=%h want 00300093/8", ok, i, p); end
`endif
   endtask

   task automatic test_reset_mid();
      bit ok; logic c; logic [31:0] i, p;
      quiesce();
      budget = 0;
      do_flush(32'h40);
      repeat (4) @(negedge clk);
      resetb = 1'b0;
      @(negedge clk);
      n_tests++; if (f_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || f_addr !== 32'h0) begin
         n_fail++; $display("FAIL midreset_state: req=%0b valid=%0b pc=%h addr=%h want 0/0/0/0", f_req, out_valid, out_pc, f_addr);
      end
      @(negedge clk);
      resetb = 1'b1;
      budget = 1000000;
      get_inst(ok, i, p, c);
      n_tests++; if (!ok || i !== 32'h13 || p !== 32'h0) begin n_fail++; $display("FAIL midreset_stale: ok=%0b inst=%h pc=%h want 00000013/0", ok, i, p); end
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = 32'h0000_0013;
      mem[32'h000 >> 2] = 32'h0000_0013;
      mem[32'h004 >> 2] = 32'h0010_0093;
      mem[32'h008 >> 2] = 32'h0030_0093;
      mem[32'h020 >> 2] = 32'h0013_4505;
      mem[32'h024 >> 2] = 32'h4505_0000;
      mem[32'h040 >> 2] = 32'h4501_4505;
      mem[32'h044 >> 2] = 32'h0000_0013;
      mem[32'h080 >> 2] = 32'h1111_1113;
      mem[32'h084 >> 2] = 32'h2222_2223;
      mem[32'h100 >> 2] = 32'h4505_0001;
      mem[32'h104 >> 2] = 32'h0050_0093;
      for (int k = 0; k < 8; k++) mem[(32'h180 >> 2) + k] = 32'h13 | (32'(k) << 20);
      mem[32'h200 >> 2] = 32'h0080_0093;
      mem[32'h300 >> 2] = 32'h0070_0093;
      resetb = 1'b0; f_gnt = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
      test_reset();
      test_first_fetch();
      test_word_kinds();
`ifdef IFA_RVC_EN
      test_straddle();
`endif
      test_flush_drop();
      test_backpressure();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_align.md
Name: ifetch_align

Overview:
- Parametrised instruction-fetch realigner between the instruction memory port and the riscv core.
- Replaces direct per-word decompression of imem_rdata; correctly handles mixed 16/32-bit (RVC) streams, including 32-bit instructions that straddle fetch-word boundaries.
- Issues word-aligned fetches with up to MAX_OS outstanding requests and buffers returned data as halfwords in a DEPTH-entry FIFO.
- Presents one raw instruction per cycle with its PC on a valid/ready handshake, and supports redirect (flush) to any halfword-aligned PC.

Parameters:
- FETCH_W, 32, fetch data width in bits; legal values 32 or 64; NH = FETCH_W/16 halfwords per fetch.
- DEPTH, 8, buffer capacity in halfwords; power of two, >= 2*NH.
- MAX_OS, 2, maximum outstanding fetch requests, 1..3.
- RESET_PC, 32'h0000_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock.
- resetb  in  1  reset, asynchronous, active-low.
- f_req  out  1  fetch request; registered.
- f_addr  out  32  fetch address, aligned to FETCH_W/8; registered.
- f_gnt  in  1  request accepted when f_req && f_gnt.
- f_rvalid  in  1  response valid; responses arrive in order.
- f_rdata  in  FETCH_W  response data, little-endian halfwords.
- flush  in  1  redirect strobe.
- flush_pc  in  32  redirect target; bit 0 ignored.
- out_valid  out  1  instruction available.
- out_ready  in  1  consumer accepts the instruction.
- out_inst  out  32  raw instruction; for 16-bit, upper half is zero.
- out_pc  out  32  PC of out_inst.
- out_is_c  out  1  out_inst is 16-bit.
- out_misalign  out  1  misaligned-target error; see Optional Feature.

Behaviour:
- Reset values: f_req=0, f_addr=RESET_PC aligned down, out_valid=0, out_pc=RESET_PC, out_is_c=0, out_misalign=0, buffer empty, os_cnt=0, drop_cnt=0, skip=RESET_PC[log2(FETCH_W/8)-1:1].
- Request issue: next-cycle f_req=1 when os_cnt(+1 if a grant occurs now) < MAX_OS and free halfwords >= NH*(os_cnt+1). This reserves buffer space so a response is never refused.
- f_req and f_addr hold while f_req && !f_gnt. On grant: os_cnt++ and f_addr += FETCH_W/8, wrapping at 2^32.
- On f_rvalid: os_cnt--.
  - If drop_cnt>0: discard the data and decrement drop_cnt.
  - Otherwise push halfwords skip..NH-1 in ascending address order, then clear skip.
  - Push is registered; out_valid can rise at the earliest on the cycle after f_rvalid.
- Output rules:
  - Head halfword has [1:0]!=2'b11: out_valid when count>=1, out_is_c=1.
  - Head halfword has [1:0]==2'b11: out_valid requires count>=2; out_inst={hw1,hw0}.
  - out_inst, out_pc and out_is_c are driven combinationally from the buffer head.
- Pop on out_valid && out_ready: remove 1 or 2 halfwords; out_pc += 2 or 4.
- Push and pop in the same cycle are legal; occupancy never exceeds DEPTH.
- Flush has priority over everything in its cycle:
  - Buffer cleared; out_valid=0 in the following cycle.
  - drop_cnt = outstanding requests, including any grant or response in the flush cycle.
  - out_pc=flush_pc; f_addr=flush_pc aligned down; skip=flush_pc[log2(FETCH_W/8)-1:1]; f_req re-evaluated from the next cycle.
  - A pending ungranted f_req is withdrawn.
- Back-to-back flushes: only the last flush takes effect.
- Reset mid-operation: all state returns immediately to reset values; responses arriving afterwards while os_cnt==0 are ignored.

Optional Feature:
- Macro IFA_RVC_EN.
- Defined:
  - 16-bit instructions supported as above.
  - out_misalign tied 0.
- Undefined:
  - Every instruction is treated as 32-bit; out_is_c tied 0.
  - Head [1:0] is not inspected; count>=2 is required.
  - A flush with flush_pc[1]=1 sets out_misalign=1 and out_valid=1 with out_pc=flush_pc and out_inst=0. Fetching is suppressed until the next flush.
  - Popping the error entry does not clear out_misalign; only the next flush does.

Test Plan:
- Reset, RESET_PC=0, grant immediately, response 32'h0000_0013 -> f_addr=0; out_valid exactly 1 cycle after f_rvalid; out_inst=32'h0000_0013, out_pc=0, out_is_c=0.
- Response 32'h4501_4505 -> out 32'h0000_4505 at pc 0, then 32'h0000_4501 at pc 2, both out_is_c=1.
- Straddle: words 32'h0013_4505 at 0, then 32'h4505_0000 at 4 -> c.li at pc 0; 32'h0000_0013 at pc 2 (out_is_c=0), valid only after the second word arrives; c.li at pc 6.
- Two outstanding requests, then flush_pc=32'h102 -> both stale responses dropped; next f_addr=32'h100; low halfword skipped; first out_pc=32'h102.
- out_ready=0 for 20 cycles with continuous grants -> f_req drops once reserved space is exhausted; no data lost; all instructions emerge in order once out_ready=1.
- IFA_RVC_EN undefined, flush_pc=32'h6 -> out_misalign=1, out_pc=6, no f_req until flush_pc=8; fetching then resumes normally.
